// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU.
//   ALU_*    : 4-bit ALU control codes understood by alu_core
//   state_t  : arbiter FSM states (IDLE, EXEC, RESP)
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational N-bit ALU.
//   a, b : operands
//   ctrl : operation code (AND, OR, ADD, SUB; any other code yields 0)
//   y    : result, carry/borrow dropped
module alu_core
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ctrl,
  output logic [N-1:0] y
);

  always_comb begin
    y = '0;
    case (ctrl)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for one shared ALU, one operation in flight.
//   clk, rst                      : clock, asynchronous active-high reset
//   req{0,1}_valid/ready          : request handshake per port
//   req{0,1}_a/b/ctrl             : operands and ALU control per port
//   rsp{0,1}_valid/ready/data     : response handshake and result per port
// Flow: IDLE (grant + latch) -> EXEC (register ALU result) -> RESP (hold until
// the owner takes it). Response appears two cycles after the request handshake.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_ctrl,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_ctrl,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [N-1:0] rsp0_data,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp1_data
);

  state_t       state;
  logic         last_grant;
  logic         owner;
  logic [N-1:0] a_reg;
  logic [N-1:0] b_reg;
  logic [3:0]   ctrl_reg;
  logic [N-1:0] result;
  logic [N-1:0] alu_y;
  logic         grant0;
  logic         grant1;

  alu_core #(.N(N)) u_alu (
    .a    (a_reg),
    .b    (b_reg),
    .ctrl (ctrl_reg),
    .y    (alu_y)
  );

  // Grants depend only on state, last_grant and request valids, so there is
  // no path from rsp*_ready. Under contention the port that did not win last
  // time is chosen. Ready is held low while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && (!req1_valid || last_grant))
        grant0 = 1'b1;
      else if (req1_valid)
        grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      ctrl_reg   <= '0;
      result     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // grant0/grant1 already include valid, so a grant is a handshake
          if (grant0 || grant1) begin
            owner      <= grant1;
            last_grant <= grant1;
            a_reg      <= grant1 ? req1_a    : req0_a;
            b_reg      <= grant1 ? req1_b    : req0_b;
            ctrl_reg   <= grant1 ? req1_ctrl : req0_ctrl;
            state      <= EXEC;
          end
        end
        EXEC: begin
          result <= alu_y;
          state  <= RESP;
        end
        RESP: begin
          if (owner ? rsp1_ready : rsp0_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Responses are decoded from registers only; the non-owner port reads 0.
  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;
  assign rsp0_data  = rsp0_valid ? result : '0;
  assign rsp1_data  = rsp1_valid ? result : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a transaction-level
// model (pending op, due cycle, result computed arithmetically).
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [63:0] rsp0_data, rsp1_data;

  int tests = 0;
  int fails = 0;

  alu_arbiter #(.N(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] ref_alu(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
    if (c == 4'd0) return a & b;
    if (c == 4'd1) return a | b;
    if (c == 4'd2) return a + b;
    if (c == 4'd6) return a - b;
    return 64'd0;
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  int          cyc = 0;
  logic        m_pend = 1'b0;
  logic        m_port = 1'b0;
  logic        m_last = 1'b1;
  int          m_due = 0;
  logic [63:0] m_res = 64'd0;

  always @(negedge clk) begin
    logic e_r0, e_r1, e_v0, e_v1, m_show;
    logic [63:0] e_d0, e_d1;
    if (rst) begin
      m_pend = 1'b0;
      m_last = 1'b1;
      e_r0 = 1'b0; e_r1 = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0;
      e_d0 = 64'd0; e_d1 = 64'd0;
    end else begin
      m_show = m_pend && (cyc >= m_due);
      e_r0 = !m_pend && req0_valid && (!req1_valid || m_last == 1'b1);
      e_r1 = !m_pend && req1_valid && (!req0_valid || m_last == 1'b0);
      e_v0 = m_show && (m_port == 1'b0);
      e_v1 = m_show && (m_port == 1'b1);
      e_d0 = e_v0 ? m_res : 64'd0;
      e_d1 = e_v1 ? m_res : 64'd0;
    end
    chk("model req0_ready", req0_ready, e_r0);
    chk("model req1_ready", req1_ready, e_r1);
    chk("model rsp0_valid", rsp0_valid, e_v0);
    chk("model rsp1_valid", rsp1_valid, e_v1);
    chk("model rsp0_data", rsp0_data, e_d0);
    chk("model rsp1_data", rsp1_data, e_d1);
    if (!rst) begin
      if (m_pend && cyc >= m_due && (m_port ? rsp1_ready : rsp0_ready)) begin
        m_pend = 1'b0;
      end else if (e_r0 || e_r1) begin
        m_pend = 1'b1;
        m_port = e_r1;
        m_last = e_r1;
        m_due  = cyc + 2;
        m_res  = e_r1 ? ref_alu(req1_a, req1_b, req1_ctrl) : ref_alu(req0_a, req0_b, req0_ctrl);
      end
      cyc++;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int p, input logic v, input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
    if (p == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rv(input int p);
    return (p == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  function automatic logic [63:0] rd(input int p);
    return (p == 0) ? rsp0_data : rsp1_data;
  endfunction

  // Single operation with the response port always ready; checks T / T+2 / T+3.
  task automatic run_op(input int p, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] c, input logic [63:0] expv, input string name);
    int n;
    drive_req(p, 1'b1, a, b, c);
    n = 0;
    @(negedge clk);
    while (!rdy(p) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " ready@T"}, rdy(p), 1'b1);
    tick;
    drive_req(p, 1'b0, 64'd0, 64'd0, 4'd0);
    @(negedge clk);
    chk({name, " valid@T+1"}, rv(p), 1'b0);
    @(negedge clk);
    chk({name, " valid@T+2"}, rv(p), 1'b1);
    chk({name, " data"}, rd(p), expv);
    @(negedge clk);
    chk({name, " idle@T+3"}, rv(p), 1'b0);
    tick;
  endtask

  task automatic contention;
    int g[$];
    int rp[$];
    logic [63:0] rdat[$];
    int n;
    rst = 1'b1;
    drive_req(0, 1'b1, 64'd1, 64'd1, ALU_ADD);
    drive_req(1, 1'b1, 64'd2, 64'd2, ALU_ADD);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    tick;
    rst = 1'b0;
    n = 0;
    while ((g.size() < 4 || rdat.size() < 4) && n < 60) begin
      @(negedge clk);
      n++;
      if (req0_ready) g.push_back(0);
      if (req1_ready) g.push_back(1);
      if (rsp0_valid) begin rp.push_back(0); rdat.push_back(rsp0_data); end
      if (rsp1_valid) begin rp.push_back(1); rdat.push_back(rsp1_data); end
      if (g.size() == 4 && (req0_valid || req1_valid)) begin
        tick;
        drive_req(0, 1'b0, 64'd0, 64'd0, 4'd0);
        drive_req(1, 1'b0, 64'd0, 64'd0, 4'd0);
      end
    end
    chk("cont grant count", g.size(), 4);
    chk("cont rsp count", rdat.size(), 4);
    for (int i = 0; i < 4 && i < g.size(); i++)
      chk($sformatf("cont grant%0d", i), g[i], i % 2);
    for (int i = 0; i < 4 && i < rdat.size(); i++) begin
      chk($sformatf("cont rsp port%0d", i), rp[i], i % 2);
      chk($sformatf("cont rsp data%0d", i), rdat[i], (i % 2) ? 64'd4 : 64'd2);
    end
    tick;
  endtask

  task automatic backpressure;
    int n;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    drive_req(0, 1'b1, 64'd7, 64'd9, ALU_ADD);
    n = 0;
    @(negedge clk);
    while (!req0_ready && n < 20) begin @(negedge clk); n++; end
    chk("bp req0 grant", req0_ready, 1'b1);
    tick;
    drive_req(0, 1'b0, 64'd0, 64'd0, 4'd0);
    drive_req(1, 1'b1, 64'd1, 64'd2, ALU_ADD);
    n = 0;
    @(negedge clk);
    while (!rsp0_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp rsp0 valid", rsp0_valid, 1'b1);
    chk("bp rsp0 data", rsp0_data, 64'd16);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp rsp0 data stable", rsp0_data, 64'd16);
      chk("bp req1 held off", req1_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp handshake cycle req1", req1_ready, 1'b0);
    @(negedge clk);
    chk("bp req1 after handshake", req1_ready, 1'b1);
    tick;
    drive_req(1, 1'b0, 64'd0, 64'd0, 4'd0);
    repeat (4) tick;
  endtask

  task automatic reset_in_exec;
    int n;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    drive_req(0, 1'b1, 64'd1, 64'd1, ALU_ADD);
    n = 0;
    @(negedge clk);
    while (!req0_ready && n < 20) begin @(negedge clk); n++; end
    chk("rst req0 grant", req0_ready, 1'b1);
    tick;
    drive_req(0, 1'b0, 64'd0, 64'd0, 4'd0);
    drive_req(1, 1'b1, 64'd3, 64'd3, ALU_ADD);
    #1;
    rst = 1'b1;
    #1;
    chk("rst async req0_ready", req0_ready, 1'b0);
    chk("rst async req1_ready", req1_ready, 1'b0);
    chk("rst async rsp0_valid", rsp0_valid, 1'b0);
    chk("rst async rsp1_valid", rsp1_valid, 1'b0);
    chk("rst async rsp0_data", rsp0_data, 64'd0);
    chk("rst async rsp1_data", rsp1_data, 64'd0);
    drive_req(1, 1'b0, 64'd0, 64'd0, 4'd0);
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst no stale rsp0", rsp0_valid, 1'b0);
    end
    tick;
    drive_req(0, 1'b1, 64'd4, 64'd4, ALU_OR);
    drive_req(1, 1'b1, 64'd5, 64'd5, ALU_OR);
    @(negedge clk);
    chk("rst post grant port0", req0_ready, 1'b1);
    chk("rst post not port1", req1_ready, 1'b0);
    tick;
    drive_req(0, 1'b0, 64'd0, 64'd0, 4'd0);
    drive_req(1, 1'b0, 64'd0, 64'd0, 4'd0);
    repeat (4) tick;
  endtask

  function automatic logic [63:0] rand_val;
    int k;
    k = $urandom_range(0, 7);
    if (k == 0) return 64'd0;
    if (k == 1) return {64{1'b1}};
    if (k == 2) return 64'd1;
    return {$urandom, $urandom};
  endfunction

  function automatic logic [3:0] rand_ctrl;
    int k;
    k = $urandom_range(0, 4);
    if (k == 0) return ALU_AND;
    if (k == 1) return ALU_OR;
    if (k == 2) return ALU_ADD;
    if (k == 3) return ALU_SUB;
    return 4'($urandom_range(0, 15));
  endfunction

  // Requester behaviour: hold the pending request (or occasionally withdraw
  // it), otherwise present a fresh random request or idle.
  task automatic rand_port(input int p, input logic hs);
    logic v;
    v = (p == 0) ? req0_valid : req1_valid;
    if (v && !hs && $urandom_range(0, 7) != 0) return;
    drive_req(p, 1'($urandom_range(0, 1)), rand_val(), rand_val(), rand_ctrl());
  endtask

  task automatic random_phase;
    logic hs0, hs1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      rand_port(0, hs0);
      rand_port(1, hs1);
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_req(0, 1'b0, 64'd0, 64'd0, 4'd0);
    drive_req(1, 1'b0, 64'd0, 64'd0, 4'd0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    tick;
    tick;
    rst = 1'b0;

    run_op(0, 64'd5, 64'd3, ALU_ADD, 64'd8, "add 5+3");
    run_op(1, 64'hF0F0, 64'h0FF0, ALU_AND, 64'h00F0, "p1 and");
    run_op(1, 64'hF0F0, 64'h0FF0, ALU_OR,  64'hFFF0, "p1 or");
    run_op(1, 64'hF0F0, 64'h0FF0, ALU_SUB, 64'hE100, "p1 sub");
    run_op(1, 64'hF0F0, 64'h0FF0, 4'b1111, 64'd0,    "p1 illegal");
    run_op(1, 64'd0, 64'd1, ALU_SUB, 64'hFFFF_FFFF_FFFF_FFFF, "p1 sub wrap");
    run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 64'd0, "add overflow");

    contention();
    backpressure();
    reset_in_exec();
    random_phase();

    drive_req(0, 1'b0, 64'd0, 64'd0, 4'd0);
    drive_req(1, 1'b0, 64'd0, 64'd0, 4'd0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (5) tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 64-bit ALU datapath between two requesters (port 0 and port 1). Each requester uses a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; one operation in flight at a time.
- Operands and control are registered, then the ALU result is registered. Sits between the decode/execute issue logic and the shared ALU.

Parameters:
- N, 64, datapath width of operands and result.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  port 0 request valid.
- req0_ready  output  1  port 0 request accepted this cycle.
- req0_a  input  N  port 0 operand 1.
- req0_b  input  N  port 0 operand 2.
- req0_ctrl  input  4  port 0 ALU control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl: same as port 0, for port 1.
- rsp0_valid  output  1  port 0 result valid.
- rsp0_ready  input  1  port 0 result consumed.
- rsp0_data  output  N  port 0 result.
- rsp1_valid, rsp1_ready, rsp1_data: same as port 0, for port 1.

Behaviour:
- Reset (async, on rst=1):
  - State = IDLE.
  - last_grant = 1, so port 0 wins the first contention.
  - Operand, control and result registers = 0.
  - All rsp*_valid = 0, all req*_ready = 0, all rsp*_data = 0.
- ALU control encoding:
  - 0000 = a AND b.
  - 0001 = a OR b.
  - 0010 = a + b (mod 2^N, carry dropped).
  - 0110 = a - b (mod 2^N, borrow dropped).
  - Any other code = result 0. An illegal code is still a legal request and produces a response.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req*_ready is combinational; exactly one port may be ready.
  - One port valid: that port is granted.
  - Both ports valid: the port != last_grant is granted.
  - reqX_ready = 1 for the granted port only.
  - On the handshake edge: latch a/b/ctrl and the owner id, set last_grant = owner, go to EXEC.
  - No valid request: stay in IDLE; both ready = 0.
- EXEC (1 cycle):
  - The ALU evaluates the latched operands.
  - At the edge: result register <= ALU output, go to RESP.
- RESP:
  - rsp<owner>_valid = 1 and rsp<owner>_data = result register. The other port's rsp_valid = 0.
  - Data holds stable while valid && !ready.
  - On rsp<owner>_ready = 1: go to IDLE.
  - No new request is accepted in the RESP cycle; all req*_ready = 0.
- Latency and throughput:
  - Request handshake at cycle T; rsp_valid asserted at cycle T+2.
  - Minimum issue interval is 3 cycles per operation.
- rsp_data of the non-owner port drives 0.
- Requester requirements: a requester must hold a/b/ctrl stable while valid && !ready. Dropping valid before ready is tolerated: no grant, no state change.
- Reset mid-operation (EXEC or RESP): the operation is discarded, with no response. Post-reset priority returns to port 0.
- Starvation bound: under continuous contention, grants alternate 0,1,0,1,...
- No combinational path from rsp*_ready to req*_ready.

Decomposition:
- Shared package alu_pkg:
  - 4-bit control constants ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110.
  - State encoding enum: IDLE, EXEC, RESP.
- One sub-module: alu_core.
  - Purely combinational: inputs a, b (N), ctrl (4); output y (N).
  - Implements the encoding above.
  - Sensitive to all inputs: operands and ctrl.
  - Instantiated once, fed from the latched registers.

Test Plan:
- Reset then single op:
  - Stimulus: req0 a=5, b=3, ctrl=0010; rsp0_ready=1.
  - Required: req0_ready=1 at T, rsp0_valid=1 with data=8 at T+2, back in IDLE at T+3.
- Full op coverage on port 1, with a=0xF0F0, b=0x0FF0:
  - AND -> 0x00F0.
  - OR -> 0xFFF0.
  - SUB -> 0xE100.
  - ctrl=1111 -> 0.
  - a=0, b=1, SUB -> 0xFFFF_FFFF_FFFF_FFFF (wrap).
- Contention:
  - Stimulus: both req valid continuously from reset, port0 ADD 1+1, port1 ADD 2+2.
  - Required: grants in order 0,1,0,1; rsp data 2,4,2,4; each owner responds only on its own rsp port.
- Backpressure:
  - Stimulus: hold rsp0_ready=0 for 5 cycles after rsp0_valid rises; req1 valid during that time.
  - Required: rsp0_data stable; req1_ready stays 0 until the cycle after the rsp0 handshake.
- Overflow:
  - Stimulus: a=0xFFFF_FFFF_FFFF_FFFF, b=1, ADD.
  - Required: result 0.
- Async reset in EXEC:
  - Stimulus: assert rst between clock edges while in EXEC.
  - Required: outputs go to 0 immediately; no rsp_valid after release; the next contention is granted to port 0.
